// File: rtl/int_gen_pkg.sv
// =============================================================================
// Module : int_gen_pkg
// Brief  : Shared FSM state type, register offsets and CTRL bit indices.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

package int_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    FIRE = 2'd3
  } state_t;

  localparam logic [3:0] c_off_ack    = 4'h0;
  localparam logic [3:0] c_off_ctrl   = 4'h4;
  localparam logic [3:0] c_off_preset = 4'h8;
  localparam logic [3:0] c_off_count  = 4'hC;

  localparam int c_ctrl_en_bit  = 0;
  localparam int c_ctrl_per_bit = 1;

endpackage

`default_nettype wire

// File: rtl/int_gen_if.sv
// =============================================================================
// Module : int_gen_if
// Brief  : CPU register bus plus interrupt line of the interrupt generator.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface int_gen_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        interrupt;

  modport master (output addr, output byteen, output wdata,
                  input  rdata, input interrupt);
  modport slave  (input  addr, input byteen, input wdata,
                  output rdata, output interrupt);
endinterface

`default_nettype wire

// File: rtl/int_gen_regs.sv
// =============================================================================
// Module : int_gen_regs
// Brief  : Address decode, byte-lane CTRL/PRESET storage and read mux.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module int_gen_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f20
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic [31:2] i_addr,
  input  wire logic [3:0]  i_byteen,
  input  wire logic [31:0] i_wdata,
  input  wire logic [31:0] i_count,
  input  wire logic        i_pending,
  input  wire logic        i_en_clr,
  output logic [31:0]      o_rdata,
  output logic             o_en,
  output logic             o_periodic,
  output logic [31:0]      o_preset,
  output logic             o_ack_wr,
  output logic             o_en_off_wr
);
  import int_gen_pkg::*;

  logic        w_hit;
  logic        w_wr;
  logic [3:0]  w_off;
  logic        w_ctrl_wr;
  logic        w_preset_wr;
  logic [31:0] w_preset_next;
  logic        r_en;
  logic        r_periodic;
  logic [31:0] r_preset;

  assign w_hit       = (i_addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr        = w_hit && (i_byteen != 4'b0000);
  assign w_off       = {i_addr[3:2], 2'b00};
  // CTRL bits all live in byte lane 0
  assign w_ctrl_wr   = w_wr && (w_off == c_off_ctrl) && i_byteen[0];
  assign w_preset_wr = w_wr && (w_off == c_off_preset);
  assign o_ack_wr    = w_wr && (w_off == c_off_ack);
  assign o_en_off_wr = w_ctrl_wr && !i_wdata[c_ctrl_en_bit];

  for (genvar g = 0; g < 4; g++) begin : g_preset_lane
    assign w_preset_next[8*g +: 8] = i_byteen[g] ? i_wdata[8*g +: 8] : r_preset[8*g +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en       <= 1'b0;
      r_periodic <= 1'b0;
      r_preset   <= 32'd0;
    end else begin
      if (w_ctrl_wr) begin
        r_en       <= i_wdata[c_ctrl_en_bit];
        r_periodic <= i_wdata[c_ctrl_per_bit];
      end else if (i_en_clr) begin
        r_en <= 1'b0;
      end
      if (w_preset_wr) begin
        r_preset <= w_preset_next;
      end
    end
  end

  always_comb begin
    o_rdata = 32'd0;
    if (w_hit) begin
      case (w_off)
        c_off_ack:    o_rdata = {31'd0, i_pending};
        c_off_ctrl:   o_rdata = {30'd0, r_periodic, r_en};
        c_off_preset: o_rdata = r_preset;
        c_off_count:  o_rdata = i_count;
        default:      o_rdata = 32'd0;
      endcase
    end
  end

  assign o_en       = r_en;
  assign o_periodic = r_periodic;
  assign o_preset   = r_preset;

endmodule

`default_nettype wire

// File: rtl/int_gen.sv
// =============================================================================
// Module : int_gen
// Brief  : Programmable one-shot/periodic countdown interrupt generator.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module int_gen #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f20
) (
  input  wire logic clk,
  input  wire logic reset,
  int_gen_if.slave  bus
);
  import int_gen_pkg::*;

  state_t      r_state;
  logic [31:0] r_count;
  logic        r_pending;
  logic        w_en;
  logic        w_periodic;
  logic [31:0] w_preset;
  logic        w_ack_wr;
  logic        w_en_off_wr;
  logic        w_en_clr;
  logic        w_fire;

  int_gen_regs #(
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk         (clk),
    .reset       (reset),
    .i_addr      (bus.addr[31:2]),
    .i_byteen    (bus.byteen),
    .i_wdata     (bus.wdata),
    .i_count     (r_count),
    .i_pending   (r_pending),
    .i_en_clr    (w_en_clr),
    .o_rdata     (bus.rdata),
    .o_en        (w_en),
    .o_periodic  (w_periodic),
    .o_preset    (w_preset),
    .o_ack_wr    (w_ack_wr),
    .o_en_off_wr (w_en_off_wr)
  );

  // Pending is raised on the edge that enters FIRE, so the interrupt is
  // already visible while the FSM sits in FIRE.
  assign w_fire   = (r_state == CNT) && !w_en_off_wr && (r_count <= 32'd1);
  assign w_en_clr = (r_state == FIRE) && !w_periodic && !w_en_off_wr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= 32'd0;
      r_pending <= 1'b0;
    end else begin
      if (w_fire) begin
        r_pending <= 1'b1;
      end else if (w_ack_wr) begin
        r_pending <= 1'b0;
      end

      if (w_en_off_wr) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: if (w_en) r_state <= LOAD;
          LOAD: begin
            r_count <= (w_preset == 32'd0) ? 32'd1 : w_preset;
            r_state <= CNT;
          end
          CNT: begin
            if (r_count > 32'd1) begin
              r_count <= r_count - 32'd1;
            end else begin
              r_count <= 32'd0;
              r_state <= FIRE;
            end
          end
          FIRE:    r_state <= w_periodic ? LOAD : IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.interrupt = r_pending;

endmodule

`default_nettype wire

// File: doc/int_gen.md
INT_GEN -- requirements
Module: int_gen

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_7f20, is the word-aligned base of the 16-byte register window.
REQ-002 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1, is the asynchronous active-high reset.
REQ-004 Port addr, input, 32, is the CPU byte address; bits [1:0] are ignored.
REQ-005 Port byteen, input, 4, carries byte write enables; nonzero means a write this cycle.
REQ-006 Port wdata, input, 32, is the write data, byte lanes aligned to byteen.
REQ-007 Port rdata, output, 32, is combinational read data for addr.
REQ-008 Port interrupt, output, 1, is the level interrupt request to the CPU; it equals the pending flag.

Function
REQ-009 The block SHALL decode a hit when addr[31:4] equals BASE_ADDR[31:4]; writes without a hit are ignored, and reads without a hit return 0.
REQ-010 Register map (offset): 0x0 ACK (W: any byteen clears pending; R: {31'b0,pending}); 0x4 CTRL (bit0 EN, bit1 PERIODIC, other bits read 0); 0x8 PRESET (32-bit, R/W); 0xC COUNT (read-only, writes ignored).
REQ-011 CTRL and PRESET writes SHALL update only the byte lanes whose byteen bits are set.
REQ-012 The FSM SHALL have states IDLE, LOAD, CNT and FIRE.
REQ-013 In IDLE, the block SHALL go to LOAD on the edge after EN becomes 1.
REQ-014 In LOAD, the block SHALL set COUNT to PRESET and go to CNT; PRESET 0 SHALL load as 1.
REQ-015 In CNT, if COUNT > 1, the block SHALL set COUNT to COUNT-1; otherwise it SHALL set COUNT to 0 and go to FIRE.
REQ-016 In FIRE, the block SHALL set pending to 1; if PERIODIC is set it SHALL go to LOAD, otherwise it SHALL go to IDLE and clear EN.
REQ-017 Latency SHALL be exact: for PRESET = N (N >= 1), interrupt rises exactly N+2 clock edges after the edge that wrote EN=1.
REQ-018 A CTRL write that clears EN in any state SHALL force IDLE on that edge; COUNT SHALL hold its value and pending SHALL be unaffected.
REQ-019 A PRESET write during CNT SHALL NOT alter COUNT; the new value SHALL apply at the next LOAD.
REQ-020 If an ACK write and FIRE occur on the same edge, pending SHALL end at 1 (set wins).
REQ-021 Pending SHALL stay set until an ACK write; repeated FIREs while pending is set SHALL NOT queue extra events.
REQ-022 If an ACK write occurs when pending is 0, the block SHALL take no action.

Reset
REQ-023 Reset SHALL asynchronously set the FSM to IDLE and clear CTRL, PRESET, COUNT and pending, so that interrupt = 0 and rdata decodes from zeroed registers.
REQ-024 Reset asserted mid-count SHALL abort the count; after release, no interrupt SHALL occur until EN is written again.

Structure
REQ-025 A shared package SHALL hold the FSM state enum, the register offset constants (ACK, CTRL, PRESET, COUNT) and the CTRL bit indices.
REQ-026 The design SHALL be a single module with one sub-module, int_gen_regs (decode, byte-lane write merge, read mux); the FSM and counter SHALL stay in int_gen.

Verification
REQ-027 PRESET=5, write CTRL=0x1 at edge E0 -> interrupt=1 from E7, COUNT reads 0, CTRL reads 0x0.
REQ-028 PRESET=3, CTRL=0x3 (periodic), ACK each interrupt within 1 cycle -> interrupt rises every 5 edges, repeatedly.
REQ-029 Periodic PRESET=1 with the ACK write placed on a FIRE edge -> pending remains 1; ACK read returns 0x1.
REQ-030 Write PRESET bytes with byteen=4'b0010 and wdata=0x0000AB00 over PRESET=0x11223344 -> PRESET reads 0x1122AB44.
REQ-031 Assert reset at COUNT=2 with PRESET=10 -> interrupt stays 0 and all registers read 0 for 20 cycles after release.
REQ-032 A write with byteen=4'hF to 0x7f30, and a read of 0x7f30 -> no register changes, and rdata=0.
